// File: rtl/nasser_hadi_ff_bank.sv
// nasser_hadi_ff_bank: WIDTH independent storage cells sharing one run-time
// mode (D / T / JK / SR). Adds a synchronous clear, a parallel load, a
// registered per-edge change flag, a saturating change counter and a sticky
// SR-illegal flag.
// Optional build macro INPUT_SYNC_EN: a and b pass through 2-flop
// synchronizers, so input-to-q latency becomes 3 clocks.
module nasser_hadi_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             changed,
    output logic [CNT_W-1:0] change_cnt,
    output logic             sr_err
);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Cell inputs as seen by the mode update logic
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_eff;

`ifdef INPUT_SYNC_EN
    logic [WIDTH-1:0] a_meta_q;
    logic [WIDTH-1:0] a_sync_q;
    logic [WIDTH-1:0] b_meta_q;
    logic [WIDTH-1:0] b_sync_q;

    // Two-stage synchronizers for the pad-driven cell inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_meta_q <= '0;
            a_sync_q <= '0;
            b_meta_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_meta_q <= a;
            a_sync_q <= a_meta_q;
            b_meta_q <= b;
            b_sync_q <= b_meta_q;
        end
    end

    assign a_eff = a_sync_q;
    assign b_eff = b_sync_q;
`else
    assign a_eff = a;
    assign b_eff = b;
`endif

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             changed_q;
    logic             changed_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sr_err_q;
    logic             sr_err_d;

    logic [WIDTH-1:0] cell_next;
    logic [WIDTH-1:0] sr_bad;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_cell
            logic nxt;

            // Per-cell next state for the currently selected mode
            always_comb begin
                nxt = q_q[gi];
                case (mode)
                    MODE_D:  nxt = a_eff[gi];
                    MODE_T:  nxt = q_q[gi] ^ a_eff[gi];
                    MODE_JK: begin
                        case ({a_eff[gi], b_eff[gi]})
                            2'b00:   nxt = q_q[gi];
                            2'b10:   nxt = 1'b1;
                            2'b01:   nxt = 1'b0;
                            default: nxt = ~q_q[gi];
                        endcase
                    end
                    default: begin
                        // SR: the illegal S=R=1 combination forces the cell low
                        case ({a_eff[gi], b_eff[gi]})
                            2'b00:   nxt = q_q[gi];
                            2'b10:   nxt = 1'b1;
                            default: nxt = 1'b0;
                        endcase
                    end
                endcase
            end

            assign cell_next[gi] = nxt;
            assign sr_bad[gi]    = (mode == MODE_SR) & a_eff[gi] & b_eff[gi];
        end
    endgenerate

    // Edge priority clr > load > enabled mode update > hold; flags follow q_d
    always_comb begin
        q_d      = q_q;
        sr_err_d = sr_err_q;
        if (clr) begin
            q_d      = RESET_VAL;
            sr_err_d = 1'b0;
        end else if (load) begin
            q_d = load_val;
        end else if (ena) begin
            q_d = cell_next;
            if (|sr_bad) begin
                sr_err_d = 1'b1;
            end
        end

        changed_d = (q_d != q_q);

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (changed_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= RESET_VAL;
            changed_q <= 1'b0;
            cnt_q     <= '0;
            sr_err_q  <= 1'b0;
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
            sr_err_q  <= sr_err_d;
        end
    end

    assign q          = q_q;
    assign changed    = changed_q;
    assign change_cnt = cnt_q;
    assign sr_err     = sr_err_q;

endmodule

// File: tb/tb_nasser_hadi_ff_bank.sv
// Testbench for nasser_hadi_ff_bank: directed scenarios plus randomized
// traffic checked against a behavioural model of the cell bank.
module tb_nasser_hadi_ff_bank;

`ifdef INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr;
    logic       load;
    logic [7:0] load_val;

    logic [7:0] q;
    logic       changed;
    logic [7:0] change_cnt;
    logic       sr_err;

    logic [7:0] q_s;
    logic       changed_s;
    logic [1:0] change_cnt_s;
    logic       sr_err_s;

    int total = 0;
    int bad   = 0;
    int edge_no = 0;

    // Behavioural model state
    logic [7:0] m_q;
    logic       m_changed;
    int         m_cnt;
    logic       m_err;
    logic [7:0] a_h0, a_h1, b_h0, b_h1;

    always #5 clk = ~clk;

    nasser_hadi_ff_bank #(.WIDTH(8), .CNT_W(8), .RESET_VAL(8'h00)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .a(a), .b(b),
        .clr(clr), .load(load), .load_val(load_val),
        .q(q), .changed(changed), .change_cnt(change_cnt), .sr_err(sr_err)
    );

    nasser_hadi_ff_bank #(.WIDTH(8), .CNT_W(2), .RESET_VAL(8'h00)) u_sat (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .a(a), .b(b),
        .clr(clr), .load(load), .load_val(load_val),
        .q(q_s), .changed(changed_s), .change_cnt(change_cnt_s), .sr_err(sr_err_s)
    );

    task automatic model_reset();
        m_q = 8'h00; m_changed = 1'b0; m_cnt = 0; m_err = 1'b0;
        a_h0 = 8'h00; a_h1 = 8'h00; b_h0 = 8'h00; b_h1 = 8'h00;
    endtask

    // One rising edge of the model, computed from the cell rules
    task automatic model_step();
        logic [7:0] ea, eb, nq;
        logic       hit;
        if (rst) begin
            model_reset();
            return;
        end
        if (LAT == 2) begin
            ea = a_h1; eb = b_h1;
            a_h1 = a_h0; a_h0 = a;
            b_h1 = b_h0; b_h0 = b;
        end else begin
            ea = a; eb = b;
        end
        hit = 1'b0;
        nq  = m_q;
        if (clr) begin
            nq = 8'h00;
        end else if (load) begin
            nq = load_val;
        end else if (ena) begin
            for (int i = 0; i < 8; i++) begin
                if (mode == 2'd0)      nq[i] = ea[i];
                else if (mode == 2'd1) nq[i] = m_q[i] ^ ea[i];
                else if (mode == 2'd2) nq[i] = (ea[i] && eb[i]) ? ~m_q[i] : (ea[i] ? 1'b1 : (eb[i] ? 1'b0 : m_q[i]));
                else begin
                    if (ea[i] && eb[i]) begin
                        nq[i] = 1'b0;
                        hit = 1'b1;
                    end else begin
                        nq[i] = ea[i] ? 1'b1 : (eb[i] ? 1'b0 : m_q[i]);
                    end
                end
            end
        end
        m_changed = (nq != m_q);
        if (clr) m_cnt = 0;
        else if (m_changed && m_cnt < 255) m_cnt = m_cnt + 1;
        if (clr) m_err = 1'b0;
        else if (hit) m_err = 1'b1;
        m_q = nq;
    endtask

    // Advance one clock: model follows the same edge; outputs settle by +1
    task automatic do_edge();
        @(posedge clk);
        model_step();
        #1;
        edge_no++;
        $display("edge %0d: rst=%0b mode=%0d ena=%0b clr=%0b load=%0b a=%h b=%h -> q=%h chg=%0b cnt=%0d err=%0b",
                 edge_no, rst, mode, ena, clr, load, a, b, q, changed, change_cnt, sr_err);
    endtask

    // Present a/b, let them pass any synchronizer with ena low, then one enabled edge
    task automatic apply(input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv);
        a = av; b = bv; mode = m; clr = 1'b0; load = 1'b0; ena = 1'b0;
        repeat (LAT) do_edge();
        ena = 1'b1;
        do_edge();
        ena = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] vals [5];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'hA5;
        rst = 1'b1; ena = 1'b0; mode = 2'd0; a = 8'h00; b = 8'h00;
        clr = 1'b0; load = 1'b0; load_val = 8'h00;
        model_reset();
        do_edge(); do_edge();
        total++;
        if ({q, changed, change_cnt, sr_err} !== {8'h00, 1'b0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got q=%h chg=%0b cnt=%0d err=%0b want 00/0/0/0", q, changed, change_cnt, sr_err);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load = 1'b1; load_val = vals[i];
            do_edge();
        end
        load = 1'b0;
        total++;
        if (q !== 8'hA5 || change_cnt !== 8'd5 || changed !== 1'b1) begin
            bad++;
            $display("FAIL preload: got q=%h cnt=%0d chg=%0b want A5/5/1", q, change_cnt, changed);
        end
        // Mid-cycle asynchronous reset must act before the next edge
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if ({q, changed, change_cnt, sr_err} !== {8'h00, 1'b0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: got q=%h chg=%0b cnt=%0d err=%0b want 00/0/0/0", q, changed, change_cnt, sr_err);
        end
        do_edge(); do_edge();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom);
            do_edge();
        end
        total++;
        if ({q, changed, change_cnt, sr_err} !== {8'h00, 1'b0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL hold_after_reset: got q=%h chg=%0b cnt=%0d err=%0b want 00/0/0/0", q, changed, change_cnt, sr_err);
        end
    endtask

    task automatic test_t_mode();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h0F; exp_q[1] = 8'h00; exp_q[2] = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            apply(2'b01, 8'h0F, 8'h00);
            total++;
            if (q !== exp_q[i] || changed !== 1'b1) begin
                bad++;
                $display("FAIL t_toggle%0d: got q=%h chg=%0b want %h/1", i, q, changed, exp_q[i]);
            end
        end
        total++;
        if (change_cnt !== 8'd3) begin
            bad++;
            $display("FAIL t_count: got %0d want 3", change_cnt);
        end
        apply(2'b01, 8'h00, 8'h00);
        total++;
        if (q !== 8'h0F || changed !== 1'b0 || change_cnt !== 8'd3) begin
            bad++;
            $display("FAIL t_hold: got q=%h chg=%0b cnt=%0d want 0F/0/3", q, changed, change_cnt);
        end
    endtask

    task automatic test_jk_sr();
        apply(2'b10, 8'hF0, 8'h0F);
        total++;
        if (q !== 8'hF0) begin
            bad++;
            $display("FAIL jk_set_clear: got q=%h want F0", q);
        end
        apply(2'b10, 8'hFF, 8'hFF);
        total++;
        if (q !== 8'h0F) begin
            bad++;
            $display("FAIL jk_toggle: got q=%h want 0F", q);
        end
        apply(2'b11, 8'h01, 8'h01);
        total++;
        if (q !== 8'h0E || sr_err !== 1'b1) begin
            bad++;
            $display("FAIL sr_illegal: got q=%h err=%0b want 0E/1", q, sr_err);
        end
        apply(2'b11, 8'h00, 8'h00);
        total++;
        if (q !== 8'h0E || sr_err !== 1'b1 || changed !== 1'b0) begin
            bad++;
            $display("FAIL sr_sticky: got q=%h err=%0b chg=%0b want 0E/1/0", q, sr_err, changed);
        end
    endtask

    task automatic test_priority();
        clr = 1'b1; load = 1'b1; ena = 1'b1; load_val = 8'hAA; mode = 2'b00; a = 8'hFF;
        do_edge();
        total++;
        if ({q, changed, change_cnt, sr_err} !== {8'h00, 1'b1, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL clr_priority: got q=%h chg=%0b cnt=%0d err=%0b want 00/1/0/0", q, changed, change_cnt, sr_err);
        end
        clr = 1'b0; load = 1'b1; ena = 1'b0; load_val = 8'h3C;
        do_edge();
        total++;
        if (q !== 8'h3C || changed !== 1'b1 || change_cnt !== 8'd1) begin
            bad++;
            $display("FAIL load: got q=%h chg=%0b cnt=%0d want 3C/1/1", q, changed, change_cnt);
        end
        do_edge();
        load = 1'b0;
        total++;
        if (q !== 8'h3C || changed !== 1'b0 || change_cnt !== 8'd1) begin
            bad++;
            $display("FAIL load_same: got q=%h chg=%0b cnt=%0d want 3C/0/1", q, changed, change_cnt);
        end
    endtask

    task automatic test_saturation();
        int want;
        clr = 1'b1; load = 1'b0; ena = 1'b0;
        do_edge();
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            apply(2'b00, (i % 2 == 0) ? 8'hFF : 8'h00, 8'h00);
            want = (i + 1 > 3) ? 3 : i + 1;
            total++;
            if (int'(change_cnt_s) != want) begin
                bad++;
                $display("FAIL sat_cnt%0d: got %0d want %0d", i, change_cnt_s, want);
            end
        end
    endtask

`ifdef INPUT_SYNC_EN
    task automatic test_sync_latency();
        mode = 2'b00; ena = 1'b1; clr = 1'b0; load = 1'b0; a = 8'h00; b = 8'h00;
        repeat (3) do_edge();
        a = 8'h55;
        for (int i = 1; i <= 3; i++) begin
            do_edge();
            total++;
            if ((i < 3 && q === 8'h55) || (i == 3 && q !== 8'h55)) begin
                bad++;
                $display("FAIL sync_latency_edge%0d: got q=%h want %s", i, q, (i < 3) ? "not 55" : "55");
            end
        end
        ena = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            mode     = 2'($urandom);
            a        = 8'($urandom);
            b        = 8'($urandom);
            ena      = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 19) == 0);
            load     = ($urandom_range(0, 9) == 0);
            load_val = 8'($urandom);
            do_edge();
            total++;
            if ({q, changed, change_cnt, sr_err} !== {m_q, m_changed, 8'(m_cnt), m_err}) begin
                bad++;
                $display("FAIL random%0d: got q=%h chg=%0b cnt=%0d err=%0b want %h/%0b/%0d/%0b",
                         n, q, changed, change_cnt, sr_err, m_q, m_changed, m_cnt, m_err);
            end
        end
        ena = 1'b0; clr = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_t_mode();
        test_jk_sr();
        test_priority();
        test_saturation();
`ifdef INPUT_SYNC_EN
        test_sync_latency();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
